// File: rtl/usb3_ep0_tx_drain_if.sv
// Bundle between the ep0 response drain and its neighbours: the ep0 response buffer side
// (buf_out_*) and the protocol-layer TX side (tx_*, pkt_*).
interface usb3_ep0_tx_drain_if;
    logic [8:0]  buf_out_addr;
    logic [31:0] buf_out_q;
    logic [10:0] buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic        tx_pkt_start;
    logic [10:0] tx_pkt_len;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  tx_be;
    logic        tx_last;
    logic        tx_ready;
    logic        pkt_ack;
    logic        pkt_retry;
    logic        tx_abort;

    modport master (
        output buf_out_addr, buf_out_arm, tx_pkt_start, tx_pkt_len, tx_valid, tx_data, tx_be,
               tx_last, tx_abort,
        input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready, pkt_ack,
               pkt_retry
    );

    modport slave (
        input  buf_out_addr, buf_out_arm, tx_pkt_start, tx_pkt_len, tx_valid, tx_data, tx_be,
               tx_last, tx_abort,
        output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, tx_ready, pkt_ack,
               pkt_retry
    );
endinterface

// File: rtl/usb3_ep0_tx_drain.sv
// Drains the ep0 response buffer into MAX_PKT-sized TX packets with per-packet ACK/retry,
// then arms ep0 to release the buffer.
module usb3_ep0_tx_drain #(
    parameter int unsigned MAX_PKT  = 512,
    parameter int unsigned READ_LAT = 2
) (
    input logic                 local_clk,
    input logic                 reset_n,
    usb3_ep0_tx_drain_if.master bus
);

    localparam int unsigned Depth  = READ_LAT + 2;
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam logic [10:0] MaxPkt = 11'(MAX_PKT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStream,
        StWaitAck,
        StArm,
        StRelease
    } state_e;

    state_e              state_q, state_d;
    logic [10:0]         total_q, total_d;
    logic [10:0]         sent_q, sent_d;
    logic [10:0]         plen_q, plen_d;
    logic [8:0]          base_q, base_d;
    logic [8:0]          addr_q, addr_d;
    logic [9:0]          issued_q, issued_d;
    logic [9:0]          popped_q, popped_d;
    logic                pkt_start_q, pkt_start_d;
    logic                abort_q, abort_d;
    logic                issue_q, issue_d;
    logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [31:0]         mem_q [Depth];
    logic [31:0]         mem_d [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [10:0] remain;
    logic [9:0]  words;
    logic        valid, push, pop, last_word, room, do_abort;
    logic [3:0]  be;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign remain    = total_q - sent_q;
    assign words     = 10'((plen_q + 11'd3) >> 2);
    assign valid     = (state_q == StStream) && (cnt_q != '0);
    assign last_word = (popped_q == words - 10'd1);
    assign pop       = valid & bus.tx_ready;
    assign push      = rd_pipe_q[READ_LAT-1];
    // Every read already issued must still fit in the FIFO once it lands.
    assign room      = (32'(cnt_q) + 32'(issue_q) + 32'($countones(rd_pipe_q)) + 32'd1)
                       <= (32'(Depth) + 32'(pop));

    always_comb begin
        be = 4'b0000;
        if (valid) begin
            be = 4'b1111;
            if (last_word) begin
                case (plen_q[1:0])
                    2'd1:    be = 4'b1000;
                    2'd2:    be = 4'b1100;
                    2'd3:    be = 4'b1110;
                    default: be = 4'b1111;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        sent_d      = sent_q;
        plen_d      = plen_q;
        base_d      = base_q;
        addr_d      = addr_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        pkt_start_d = 1'b0;
        abort_d     = 1'b0;
        issue_d     = 1'b0;
        do_abort    = 1'b0;

        rd_pipe_d[0] = issue_q;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.buf_out_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);

        case (state_q)
            StIdle: begin
                if (bus.buf_out_hasdata) begin
                    state_d = StStart;
                    total_d = bus.buf_out_len;
                    sent_d  = '0;
                    base_d  = '0;
                end
            end
            StStart: begin
                if (!bus.buf_out_hasdata) begin
                    do_abort = 1'b1;
                end else begin
                    plen_d      = (remain > MaxPkt) ? MaxPkt : remain;
                    pkt_start_d = 1'b1;
                    popped_d    = '0;
                    issued_d    = '0;
                    if (plen_d == '0) begin
                        state_d = StWaitAck;
                    end else begin
                        state_d  = StStream;
                        issue_d  = 1'b1;
                        addr_d   = base_q;
                        issued_d = 10'd1;
                    end
                end
            end
            StStream: begin
                if (!bus.buf_out_hasdata) begin
                    do_abort = 1'b1;
                end else begin
                    if ((issued_q < words) && room) begin
                        issue_d  = 1'b1;
                        addr_d   = base_q + 9'(issued_q);
                        issued_d = issued_q + 10'd1;
                    end
                    if (pop) begin
                        popped_d = popped_q + 10'd1;
                        if (last_word) begin
                            state_d = StWaitAck;
                        end
                    end
                end
            end
            StWaitAck: begin
                if (!bus.buf_out_hasdata) begin
                    do_abort = 1'b1;
                end else if (bus.pkt_retry) begin
                    state_d = StStart;
                end else if (bus.pkt_ack) begin
                    sent_d  = sent_q + plen_q;
                    base_d  = base_q + 9'(plen_q >> 2);
                    state_d = (sent_d < total_q) ? StStart : StArm;
                end
            end
            StArm: begin
                if (bus.buf_out_arm_ack) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!bus.buf_out_hasdata) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // ep0 withdrew the response: flush everything in flight and skip the arm handshake.
        if (do_abort) begin
            state_d     = StIdle;
            abort_d     = 1'b1;
            pkt_start_d = 1'b0;
            issue_d     = 1'b0;
            rd_pipe_d   = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            total_q     <= '0;
            sent_q      <= '0;
            plen_q      <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            pkt_start_q <= 1'b0;
            abort_q     <= 1'b0;
            issue_q     <= 1'b0;
            rd_pipe_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            sent_q      <= sent_d;
            plen_q      <= plen_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            pkt_start_q <= pkt_start_d;
            abort_q     <= abort_d;
            issue_q     <= issue_d;
            rd_pipe_q   <= rd_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge local_clk) begin
        mem_q <= mem_d;
    end

    assign bus.buf_out_addr = addr_q;
    assign bus.buf_out_arm  = (state_q == StArm);
    assign bus.tx_pkt_start = pkt_start_q;
    assign bus.tx_pkt_len   = plen_q;
    assign bus.tx_valid     = valid;
    assign bus.tx_data      = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.tx_be        = be;
    assign bus.tx_last      = valid & last_word;
    assign bus.tx_abort     = abort_q;

endmodule

// File: tb/tb_usb3_ep0_tx_drain.sv
// Randomized bench for usb3_ep0_tx_drain: a ROM with two-cycle read latency feeds the DUT and
// every packet is checked against a packet plan derived from the transfer length.
module tb_usb3_ep0_tx_drain;
    localparam int unsigned MaxPkt  = 512;
    localparam int unsigned ReadLat = 2;

    typedef struct packed {
        int plen;
        int base;
    } pkt_t;

    logic local_clk = 1'b0;
    logic reset_n   = 1'b0;

    usb3_ep0_tx_drain_if bus ();

    usb3_ep0_tx_drain #(
        .MAX_PKT  (MaxPkt),
        .READ_LAT (ReadLat)
    ) dut (
        .local_clk (local_clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 local_clk = ~local_clk;

    logic [31:0] rom [512];
    logic [8:0]  rd_a1, rd_a2;
    always @(posedge local_clk) begin
        rd_a1 <= bus.buf_out_addr;
        rd_a2 <= rd_a1;
    end
    assign bus.buf_out_q = rom[rd_a2];

    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   bp_pct = 0;
    pkt_t plan_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive tx_ready after the falling edge, then sample outputs.
    task automatic step();
        @(negedge local_clk);
        bus.tx_ready = ($urandom_range(99) >= bp_pct);
        #1;
        cyc++;
    endtask

    function automatic void build_plan(input int len);
        int sent = 0;
        plan_q.delete();
        do begin
            pkt_t pk;
            pk.plen = (len - sent > int'(MaxPkt)) ? int'(MaxPkt) : len - sent;
            pk.base = sent / 4;
            plan_q.push_back(pk);
            sent += pk.plen;
        end while (sent < len);
    endfunction

    function automatic logic [3:0] exp_be(input int plen, input int idx);
        int nw = (plen + 3) / 4;
        if (idx == nw - 1) begin
            case (plen % 4)
                1: return 4'b1000;
                2: return 4'b1100;
                3: return 4'b1110;
                default: return 4'b1111;
            endcase
        end
        return 4'b1111;
    endfunction

    task automatic run_xfer(input int len, input int retry_pkt, input bit retry_with_ack,
                            input int abort_beat, input bit stray_ack, input bit reset_in_arm);
        int plen, base, nw, attempts, t, beat, start_cyc;
        bit first, stalled;
        logic [31:0] pdata;
        logic [3:0]  pbe;
        logic        plast;

        build_plan(len);
        bus.buf_out_len     = 11'(len);
        bus.buf_out_hasdata = 1'b1;
        step();
        check_val("pkt_start_early", bus.tx_pkt_start, 0);

        for (int p = 0; p < plan_q.size(); p++) begin
            plen     = plan_q[p].plen;
            base     = plan_q[p].base;
            nw       = (plen + 3) / 4;
            attempts = (p == retry_pkt) ? 2 : 1;
            for (int a = 0; a < attempts; a++) begin
                t = 0;
                do begin
                    step();
                    t++;
                end while (!bus.tx_pkt_start && t < 20);
                if (!bus.tx_pkt_start) begin
                    check_val("pkt_start_timeout", 0, 1);
                    return;
                end
                if (p == 0 && a == 0) check_val("pkt_start_lat", 64'(t), 1);
                check_val("pkt_len", bus.tx_pkt_len, 64'(plen));
                start_cyc = cyc;
                beat      = 0;
                first     = 1'b1;
                stalled   = 1'b0;
                t         = 0;
                while (beat < nw && t < 4000) begin
                    step();
                    t++;
                    if (stalled) begin
                        check_val("stall_valid", bus.tx_valid, 1);
                        check_val("stall_data", bus.tx_data, pdata);
                        check_val("stall_be", bus.tx_be, pbe);
                        check_val("stall_last", bus.tx_last, plast);
                    end
                    if (bus.tx_valid && first) begin
                        check_val("first_valid_lat", 64'(cyc - start_cyc), 64'(ReadLat + 1));
                        first = 1'b0;
                    end
                    if (bus.tx_valid && bus.tx_ready) begin
                        check_val("data", bus.tx_data, rom[base + beat]);
                        check_val("be", bus.tx_be, exp_be(plen, beat));
                        check_val("last", bus.tx_last, 64'(beat == nw - 1));
                        beat++;
                        if (p == 0 && beat == abort_beat) begin
                            bus.pkt_ack         = 1'b0;
                            bus.buf_out_hasdata = 1'b0;
                            step();
                            check_val("abort_pulse", bus.tx_abort, 1);
                            check_val("abort_valid", bus.tx_valid, 0);
                            step();
                            check_val("abort_single", bus.tx_abort, 0);
                            repeat (4) begin
                                step();
                                check_val("abort_no_arm", bus.buf_out_arm, 0);
                                check_val("abort_no_start", bus.tx_pkt_start, 0);
                            end
                            return;
                        end
                    end
                    stalled     = bus.tx_valid && !bus.tx_ready;
                    pdata       = bus.tx_data;
                    pbe         = bus.tx_be;
                    plast       = bus.tx_last;
                    bus.pkt_ack = stray_ack && (t == 3);
                end
                bus.pkt_ack = 1'b0;
                if (beat < nw) begin
                    check_val("stream_timeout", 64'(beat), 64'(nw));
                    return;
                end
                repeat (2) begin
                    step();
                    check_val("quiet_valid", bus.tx_valid, 0);
                    check_val("quiet_arm", bus.buf_out_arm, 0);
                end
                if (a < attempts - 1) begin
                    bus.pkt_retry = 1'b1;
                    bus.pkt_ack   = retry_with_ack;
                end else begin
                    bus.pkt_ack = 1'b1;
                end
                step();
                bus.pkt_retry = 1'b0;
                bus.pkt_ack   = 1'b0;
            end
        end

        check_val("arm_set", bus.buf_out_arm, 1);
        repeat (2) begin
            step();
            check_val("arm_hold", bus.buf_out_arm, 1);
        end
        if (reset_in_arm) begin
            reset_n = 1'b0;
            step();
            check_val("rst_arm", bus.buf_out_arm, 0);
            check_val("rst_valid", bus.tx_valid, 0);
            check_val("rst_abort", bus.tx_abort, 0);
            check_val("rst_addr", bus.buf_out_addr, 0);
            check_val("rst_len", bus.tx_pkt_len, 0);
            reset_n             = 1'b1;
            bus.buf_out_hasdata = 1'b0;
            step();
            return;
        end
        bus.buf_out_arm_ack = 1'b1;
        step();
        check_val("arm_release", bus.buf_out_arm, 0);
        repeat (3) step();
        bus.buf_out_arm_ack = 1'b0;
        repeat (4) begin
            step();
            check_val("stale_no_start", bus.tx_pkt_start, 0);
            check_val("stale_no_arm", bus.buf_out_arm, 0);
        end
        bus.buf_out_hasdata = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, npk, rp;
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        bus.buf_out_len     = '0;
        bus.buf_out_hasdata = 1'b0;
        bus.buf_out_arm_ack = 1'b0;
        bus.tx_ready        = 1'b1;
        bus.pkt_ack         = 1'b0;
        bus.pkt_retry       = 1'b0;
        repeat (3) step();
        check_val("reset_addr", bus.buf_out_addr, 0);
        check_val("reset_arm", bus.buf_out_arm, 0);
        check_val("reset_start", bus.tx_pkt_start, 0);
        check_val("reset_len", bus.tx_pkt_len, 0);
        check_val("reset_valid", bus.tx_valid, 0);
        check_val("reset_data", bus.tx_data, 0);
        check_val("reset_be", bus.tx_be, 0);
        check_val("reset_last", bus.tx_last, 0);
        check_val("reset_abort", bus.tx_abort, 0);
        reset_n = 1'b1;
        step();

        bp_pct = 0;
        run_xfer(18, -1, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(0, -1, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(1030, -1, 1'b0, -1, 1'b0, 1'b0);
        bp_pct = 50;
        run_xfer(44, -1, 1'b0, -1, 1'b1, 1'b0);
        bp_pct = 0;
        run_xfer(1030, 1, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(1030, 1, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(100, -1, 1'b0, 6, 1'b0, 1'b0);
        run_xfer(8, -1, 1'b0, -1, 1'b0, 1'b1);
        run_xfer(23, -1, 1'b0, -1, 1'b0, 1'b0);

        repeat (8) begin
            len    = $urandom_range(0, 2047);
            bp_pct = $urandom_range(0, 60);
            npk    = (len == 0) ? 1 : (len + int'(MaxPkt) - 1) / int'(MaxPkt);
            rp     = $urandom_range(0, npk);
            run_xfer(len, (rp == npk) ? -1 : rp, 1'($urandom_range(0, 1)), -1,
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb3_ep0_tx_drain.md
Name: usb3_ep0_tx_drain

Overview:
- Downstream consumer of the endpoint-0 response buffer, sitting between ep0 and the protocol-layer TX path.
- When ep0 flags buf_out_hasdata, the block reads buf_out_len bytes word-by-word from ep0's descriptor/response memory.
- It streams them as one or more data packets of at most MAX_PKT bytes, with per-packet host ACK and retry.
- It then pulses the ep0 arm handshake to release the buffer.

Parameters:
- MAX_PKT, 512, maximum bytes per data packet (multiple of 4, ≤ 2044).
- READ_LAT, 2, cycles from buf_out_addr change to valid buf_out_q.

Ports:
- local_clk  in  1  sole clock.
- reset_n  in  1  reset, synchronous, active-low.
- buf_out_addr  out  9  word address into ep0 response memory.
- buf_out_q  in  32  read data; byte 0 in [31:24].
- buf_out_len  in  11  response length in bytes.
- buf_out_hasdata  in  1  ep0 has a response pending.
- buf_out_arm  out  1  level request to release the ep0 buffer.
- buf_out_arm_ack  in  1  ep0 acknowledges arm (held ≥4 cycles).
- tx_pkt_start  out  1  one-cycle pulse; tx_pkt_len valid.
- tx_pkt_len  out  11  bytes in the packet about to stream.
- tx_valid  out  1  tx_data valid.
- tx_data  out  32  payload word.
- tx_be  out  4  byte enables, [3] = byte in [31:24].
- tx_last  out  1  final word of the current packet.
- tx_ready  in  1  downstream accepts word when tx_valid & tx_ready.
- pkt_ack  in  1  pulse: host ACKed the packet just sent.
- pkt_retry  in  1  pulse: host requests retransmission of the packet just sent.
- tx_abort  out  1  one-cycle pulse when a transfer is abandoned.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, buf_out_addr=0, FSM=IDLE, skid FIFO empty, counters 0. Reset mid-transfer drops tx_valid and buf_out_arm the same edge. No tx_abort on reset.
- FSM states and transitions:
  - IDLE: when buf_out_hasdata=1 -> START. Latch total=buf_out_len, base=0.
  - START: plen=min(total-sent, MAX_PKT). Pulse tx_pkt_start with tx_pkt_len=plen. If plen=0 (ZLP) -> WAIT_ACK with no data words; else -> STREAM.
  - STREAM: words=ceil(plen/4). Addresses are issued from base, pipelined one per cycle while the skid FIFO (depth READ_LAT+2) has room for all in-flight reads. A FIFO entry is presented on tx_data when non-empty. tx_data/tx_be/tx_last are held stable while tx_valid & ~tx_ready. After the word with tx_last is accepted -> WAIT_ACK.
  - WAIT_ACK:
    - pkt_retry -> START with the same base and plen.
    - pkt_ack: sent+=plen, base+=plen/4. If sent<total -> START, else -> ARM.
    - pkt_ack and pkt_retry in the same cycle: retry wins.
  - ARM: buf_out_arm=1 until buf_out_arm_ack=1 is sampled, then buf_out_arm=0 -> RELEASE.
  - RELEASE: wait for buf_out_hasdata=0, then -> IDLE. A transfer is never restarted on a stale hasdata.
- tx_be: 4'b1111 for all words except the last word of a packet whose plen[1:0]≠0: 1→1000, 2→1100, 3→1110.
- ZLP only when buf_out_len=0 (ep0 zero-byte status responses). No trailing ZLP after a final full MAX_PKT packet.
- Latency: tx_pkt_start is asserted 2 cycles after hasdata rises. The first tx_valid is asserted READ_LAT+1 cycles after tx_pkt_start. Steady-state throughput is 1 word/cycle with tx_ready=1.
- Abort: if buf_out_hasdata falls in START, STREAM or WAIT_ACK:
  - pulse tx_abort, flush the FIFO, discard in-flight reads, drop tx_valid next cycle;
  - go to IDLE without arming.
- pkt_ack/pkt_retry outside WAIT_ACK are ignored.
- Width rules: byte counters are 11 bits and word address is 9 bits. base never exceeds 511 because total ≤ 2047.

Test Plan:
- Device descriptor, buf_out_len=18, q from a model ROM (READ_LAT=2), tx_ready=1 -> tx_pkt_len=18, 5 words, last tx_be=1100, addr 0..4. After pkt_ack, arm high until ack, then idle after hasdata=0.
- buf_out_len=0 (SET_ADDRESS status) -> tx_pkt_start with len 0, no tx_valid. pkt_ack -> arm handshake completes.
- buf_out_len=1030, MAX_PKT=512 -> packets 512/512/6 with bases 0/128/256; final packet 2 words, last tx_be=1100. Arm only after the third ack.
- Random tx_ready backpressure at 50% on a 44-byte transfer -> the data sequence matches the ROM exactly, with no drops or duplicates and outputs stable while stalled.
- pkt_retry on packet 2 of 1030 bytes -> packet 2 is resent from word 128 with identical data. pkt_ack and pkt_retry asserted in the same cycle -> treated as retry.
- Drop hasdata mid-STREAM -> tx_abort pulse, tx_valid low next cycle, no arm. Assert reset_n=0 during ARM -> arm low on that edge, FSM IDLE.
